// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
//
// Fetch stage that sits directly in front of a 2^AW x IW combinational
// instruction ROM. It owns the program counter, drives the ROM address from
// it, and captures the ROM word into a fetch register (instruction, PC,
// valid) for the decode stage. A small IDLE/RUN/DONE sequencer starts and
// halts a program run. Absolute branches squash the one wrong-path fetch.
// A saturating counter records how many cycles the run has spent in RUN.
//
// Ports
//   Clk            in   rising-edge clock
//   Reset_n        in   asynchronous active-low reset
//   start          in   begin a run at start_addr (only from IDLE or DONE)
//   start_addr     in   [AW] first instruction address
//   stall          in   decode not ready: hold fetch register and PC
//   branch_taken   in   redirect to branch_target (needs inst_valid)
//   branch_target  in   [AW] absolute branch target
//   halt_req       in   decode holds a halt instruction (needs inst_valid)
//   rom_addr       out  [AW] ROM address, always equal to the PC register
//   rom_data       in   [IW] combinational ROM data for rom_addr
//   inst_q         out  [IW] registered instruction
//   inst_pc        out  [AW] address inst_q was fetched from
//   inst_valid     out  inst_q is a live instruction
//   busy           out  sequencer is in RUN
//   done           out  sequencer is in DONE (held until the next start)
//   cycle_count    out  [CW] RUN cycles of the current/last run, saturating
// ---------------------------------------------------------------------------
module inst_fetch #(
    parameter int AW = 11,
    parameter int IW = 9,
    parameter int CW = 16
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    input  logic          stall,
    input  logic          branch_taken,
    input  logic [AW-1:0] branch_target,
    input  logic          halt_req,
    output logic [AW-1:0] rom_addr,
    input  logic [IW-1:0] rom_data,
    output logic [IW-1:0] inst_q,
    output logic [AW-1:0] inst_pc,
    output logic          inst_valid,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] cycle_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q,    pc_d;
    logic [IW-1:0] instr_q, instr_d;
    logic [AW-1:0] ipc_q,   ipc_d;
    logic          vld_q,   vld_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        if (&v) begin
            return v;
        end
        return v + CW'(1);
    endfunction

    // Sequencer state register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sequencer next state. Halt/branch are only meaningful when the
    // fetch register holds a live instruction; otherwise they are noise.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (halt_req && vld_q) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer outputs, decoded purely from the state register.
    always_comb begin
        busy = (state_q == S_RUN);
        done = (state_q == S_DONE);
    end

    // Fetch datapath next-state. Priority inside RUN is halt, then branch
    // (which deliberately overrides stall so the redirect is never lost),
    // then stall, then a normal fetch.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        vld_d   = vld_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    pc_d  = start_addr;
                    vld_d = 1'b0;
                    cnt_d = '0;
                end
            end
            S_RUN: begin
                // Every RUN edge counts, stalled and halting edges included.
                cnt_d = sat_inc(cnt_q);
                if (halt_req && vld_q) begin
                    vld_d = 1'b0;
                end else if (branch_taken && vld_q) begin
                    // The word at pc_q is wrong-path; drop it by not loading.
                    pc_d  = branch_target;
                    vld_d = 1'b0;
                end else if (!stall) begin
                    instr_d = rom_data;
                    ipc_d   = pc_q;
                    vld_d   = 1'b1;
                    pc_d    = pc_q + AW'(1);  // wraps modulo 2^AW
                end
            end
            default: begin
                vld_d = 1'b0;
            end
        endcase
    end

    // Fetch datapath registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pc_q    <= '0;
            instr_q <= '0;
            ipc_q   <= '0;
            vld_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rom_addr    = pc_q;
    assign inst_q      = instr_q;
    assign inst_pc     = ipc_q;
    assign inst_valid  = vld_q;
    assign cycle_count = cnt_q;

endmodule

// File: tb/tb_inst_fetch.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch
//
// Drives inst_fetch against a small directed ROM image. Expected fetched
// instructions are queued as stimulus is issued; a monitor pops one entry
// each cycle decode consumes a live instruction and compares it. Sequencer
// and counter outputs are checked directly at fixed points. A second
// instance built with CW=4 shares the stimulus to exercise counter
// saturation.
// ---------------------------------------------------------------------------
module tb_inst_fetch;

    localparam int AW = 11;
    localparam int IW = 9;
    localparam int CW = 16;

    logic          Clk;
    logic          Reset_n;
    logic          start;
    logic [AW-1:0] start_addr;
    logic          stall;
    logic          branch_taken;
    logic [AW-1:0] branch_target;
    logic          halt_req;
    logic [AW-1:0] rom_addr;
    logic [IW-1:0] rom_data;
    logic [IW-1:0] inst_q;
    logic [AW-1:0] inst_pc;
    logic          inst_valid;
    logic          busy;
    logic          done;
    logic [CW-1:0] cycle_count;

    logic [AW-1:0] rom_addr_4;
    logic [IW-1:0] inst_q_4;
    logic [AW-1:0] inst_pc_4;
    logic          inst_valid_4;
    logic          busy_4;
    logic          done_4;
    logic [3:0]    cycle_count_4;

    logic [IW-1:0] rom [0:(1<<AW)-1];
    assign rom_data = rom[rom_addr];

    int n_checks = 0;
    int n_fail   = 0;

    // {instruction, pc}
    logic [IW+AW-1:0] exp_q[$];

    inst_fetch #(.AW(AW), .IW(IW), .CW(CW)) u_dut (
        .Clk(Clk), .Reset_n(Reset_n), .start(start), .start_addr(start_addr),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .halt_req(halt_req), .rom_addr(rom_addr), .rom_data(rom_data),
        .inst_q(inst_q), .inst_pc(inst_pc), .inst_valid(inst_valid),
        .busy(busy), .done(done), .cycle_count(cycle_count)
    );

    inst_fetch #(.AW(AW), .IW(IW), .CW(4)) u_dut4 (
        .Clk(Clk), .Reset_n(Reset_n), .start(start), .start_addr(start_addr),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .halt_req(halt_req), .rom_addr(rom_addr_4), .rom_data(rom_data),
        .inst_q(inst_q_4), .inst_pc(inst_pc_4), .inst_valid(inst_valid_4),
        .busy(busy_4), .done(done_4), .cycle_count(cycle_count_4)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic push(input logic [IW-1:0] i, input logic [AW-1:0] p);
        exp_q.push_back({i, p});
    endtask

    task automatic check_reset_outputs();
        check("rst_rom_addr", 32'(rom_addr), 0);
        check("rst_inst_q", 32'(inst_q), 0);
        check("rst_inst_pc", 32'(inst_pc), 0);
        check("rst_inst_valid", 32'(inst_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_cycle_count", 32'(cycle_count), 0);
    endtask

    // Monitor: decode consumes the fetch register when it is valid and
    // either not stalled or acting on a branch/halt held in it.
    initial begin
        logic [IW+AW-1:0] e;
        forever begin
            @(negedge Clk);
            if (Reset_n === 1'b1 && inst_valid === 1'b1 &&
                (!stall || branch_taken || halt_req)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_inst_pc", 32'(inst_pc), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("inst_q", 32'(inst_q), 32'(e[IW+AW-1:AW]));
                    check("inst_pc", 32'(inst_pc), 32'(e[AW-1:0]));
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) rom[i] = '0;
        rom[0]      = 9'h001;
        rom[1]      = 9'h002;
        rom[2]      = 9'h003;
        rom[3]      = 9'h004;
        rom[4]      = 9'h005;
        rom[5]      = 9'h006;
        rom[11'h100] = 9'h0A0;
        rom[11'h101] = 9'h0A1;
        rom[11'h102] = 9'h0A2;
        rom[11'h7FE] = 9'h1FE;
        rom[11'h7FF] = 9'h1FF;

        Reset_n = 1'b1; start = 1'b0; start_addr = '0; stall = 1'b0;
        branch_taken = 1'b0; branch_target = '0; halt_req = 1'b0;
        #1 Reset_n = 1'b0;
        #1;
        check_reset_outputs();
        tick(); tick();
        Reset_n = 1'b1;

        // Start at 0
        start = 1'b1; start_addr = 11'h000;
        push(9'h001, 11'h000); push(9'h002, 11'h001); push(9'h003, 11'h002);
        push(9'h004, 11'h003); push(9'h005, 11'h004);
        tick();                                          // E0
        start = 1'b0;
        check("start_busy", 32'(busy), 1);
        check("start_valid_low", 32'(inst_valid), 0);
        check("start_rom_addr", 32'(rom_addr), 0);
        tick();                                          // E1
        check("first_valid", 32'(inst_valid), 1);
        check("first_inst_pc", 32'(inst_pc), 0);
        tick();                                          // E2
        tick();                                          // E3: inst_pc=2

        // Stall for three edges
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin                // E4..E6
            tick();
            check("stall_inst_pc", 32'(inst_pc), 2);
            check("stall_inst_q", 32'(inst_q), 3);
            check("stall_valid", 32'(inst_valid), 1);
            check("stall_rom_addr", 32'(rom_addr), 3);
        end
        check("stall_cycle_count", 32'(cycle_count), 6);
        stall = 1'b0;
        tick();                                          // E7
        check("resume_inst_pc", 32'(inst_pc), 3);
        tick();                                          // E8: inst_pc=4

        // Branch overriding stall
        branch_taken = 1'b1; stall = 1'b1; branch_target = 11'h100;
        push(9'h0A0, 11'h100); push(9'h0A1, 11'h101); push(9'h0A2, 11'h102);
        tick();                                          // E9
        check("branch_bubble", 32'(inst_valid), 0);
        check("branch_rom_addr", 32'(rom_addr), 32'h100);
        // Branch while inst_valid=0 must be ignored
        branch_target = 11'h050; stall = 1'b0;
        tick();                                          // E10
        check("branch_tgt_valid", 32'(inst_valid), 1);
        check("branch_tgt_pc", 32'(inst_pc), 32'h100);
        check("branch_ignored_rom_addr", 32'(rom_addr), 32'h101);
        branch_taken = 1'b0;
        tick();                                          // E11
        tick();                                          // E12: inst_pc=0x102

        // Halt
        halt_req = 1'b1;
        tick();                                          // E13
        halt_req = 1'b0;
        check("halt_done", 32'(done), 1);
        check("halt_busy", 32'(busy), 0);
        check("halt_valid", 32'(inst_valid), 0);
        check("halt_cycle_count", 32'(cycle_count), 13);
        check("halt_inst_pc", 32'(inst_pc), 32'h102);
        check("halt_rom_addr", 32'(rom_addr), 32'h103);
        tick();                                          // E14
        check("done_hold", 32'(done), 1);
        check("done_count_hold", 32'(cycle_count), 13);

        // Restart near the top of memory, PC wraps
        start = 1'b1; start_addr = 11'h7FE;
        push(9'h1FE, 11'h7FE); push(9'h1FF, 11'h7FF);
        push(9'h001, 11'h000); push(9'h002, 11'h001);
        tick();                                          // E15
        start = 1'b0;
        check("restart_done", 32'(done), 0);
        check("restart_busy", 32'(busy), 1);
        check("restart_count", 32'(cycle_count), 0);
        check("restart_rom_addr", 32'(rom_addr), 32'h7FE);
        tick(); tick(); tick();                          // E16..E18
        check("wrap_rom_addr", 32'(rom_addr), 1);
        check("wrap_count", 32'(cycle_count), 3);

        // Start while running is ignored
        start = 1'b1; start_addr = 11'h200;
        tick();                                          // E19
        start = 1'b0;
        check("run_start_busy", 32'(busy), 1);
        check("run_start_inst_pc", 32'(inst_pc), 1);
        check("run_start_rom_addr", 32'(rom_addr), 2);

        // Asynchronous reset between edges
        @(negedge Clk);
        #1;
        Reset_n = 1'b0;
        #1;
        check_reset_outputs();
        start = 1'b1; start_addr = 11'h003;
        tick();                                          // E20 in reset
        Reset_n = 1'b1;
        push(9'h004, 11'h003);
        tick();                                          // E21
        start = 1'b0;
        check("post_rst_busy", 32'(busy), 1);
        check("post_rst_rom_addr", 32'(rom_addr), 3);
        tick();                                          // E22
        tick();                                          // E23

        // Saturation on the CW=4 build
        stall = 1'b1;
        repeat (13) tick();
        check("sat4_reach", 32'(cycle_count_4), 15);
        check("wide_count_15", 32'(cycle_count), 15);
        repeat (7) tick();
        check("sat4_hold", 32'(cycle_count_4), 15);
        check("wide_count_22", 32'(cycle_count), 22);
        stall = 1'b0;

        check("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
